uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter between two message sources: the LPC capture dumper (channel 0) and the status/debug source (channel 1). Sits between the requesters and the UART TX byte interface. It grants one whole 48-bit message at a time with round-robin fairness and serialises it as a framed 8-byte packet. It owns the UART byte handshake and flags a stuck transmitter with a timeout.

---
 rtl/uart_tx_arbiter_if.sv | 40 ++++
 rtl/uart_tx_arbiter.sv | 150 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
//   Bundles the two requester channels and the UART TX byte handshake that
//   uart_tx_arbiter sits between.
//
//   Signals:
//     req0/req1            requester has a message pending
//     msg0/msg1            48-bit message, stable while req is high
//     grant0/grant1        one-clock pulse: message latched
//     uart_ready           transmitter idle and able to accept a byte
//     uart_data            byte to transmit
//     uart_clock_enable    byte-valid strobe to the transmitter
//     busy                 packet in progress
//     timeout_err          sticky handshake-timeout flag
//
//   Modports:
//     slave  - the arbiter side (drives grants and the UART byte outputs)
//     master - the environment side (requesters plus transmitter)
interface uart_tx_arbiter_if;
  logic        req0;
  logic [47:0] msg0;
  logic        grant0;
  logic        req1;
  logic [47:0] msg1;
  logic        grant1;
  logic        uart_ready;
  logic [7:0]  uart_data;
  logic        uart_clock_enable;
  logic        busy;
  logic        timeout_err;

  modport slave (
    input  req0, msg0, req1, msg1, uart_ready,
    output grant0, grant1, uart_data, uart_clock_enable, busy, timeout_err
  );

  modport master (
    output req0, msg0, req1, msg1, uart_ready,
    input  grant0, grant1, uart_data, uart_clock_enable, busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter between two 48-bit message sources
//   (channel 0: LPC capture dumper, channel 1: status/debug). One whole
//   message is granted at a time, round-robin on ties, and sent as an
//   8-byte packet: header (HEADER_BASE | src), six message bytes MSB first,
//   then TRAILER. A transmitter that never drops uart_ready after a byte
//   strobe aborts the packet and sets the sticky timeout_err.
//
//   Ports:
//     clock    system clock; all state changes on the FALLING edge so the
//              block lines up with the UART-side logic
//     reset    asynchronous, active-low
//     bus      uart_tx_arbiter_if.slave (requesters + UART byte interface)
//     state_o  current FSM state (0 IDLE, 1 SEND, 2 WAIT_ACK) for observation
//
//   Byte handshake: in SEND the byte is offered (uart_data valid,
//   uart_clock_enable high) once uart_ready is high; the transmitter
//   acknowledges by pulling uart_ready low, which drops the strobe on that
//   same edge. Requester handshake: req/msg held until the grant pulse; the
//   grant means the message is already in the internal buffer.
module uart_tx_arbiter #(
  parameter logic [7:0] HEADER_BASE = 8'hA0,
  parameter logic [7:0] TRAILER     = 8'h0A,
  parameter int         TIMEOUT     = 1024
) (
  input  logic               clock,
  input  logic               reset,
  uart_tx_arbiter_if.slave   bus,
  output logic [1:0]         state_o
);

  localparam int             TW   = $clog2(TIMEOUT);
  localparam logic [TW-1:0]  TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  state_t        state_q;
  logic [47:0]   buf_q;
  logic          src_q;
  logic          last_src_q;
  logic [2:0]    idx_q;
  logic [TW-1:0] timer_q;
  logic [7:0]    data_q;
  logic          en_q;
  logic          grant0_q;
  logic          grant1_q;
  logic          busy_q;
  logic          err_q;

  logic          pick1;
  logic [7:0]    tx_byte;

  // Channel 1 wins when it is the only requester, or on a tie when
  // channel 0 was served last.
  assign pick1 = bus.req1 & (~bus.req0 | ~last_src_q);

  always_comb begin
    tx_byte = TRAILER;
    case (idx_q)
      3'd0:    tx_byte = HEADER_BASE | {7'd0, src_q};
      3'd1:    tx_byte = buf_q[47:40];
      3'd2:    tx_byte = buf_q[39:32];
      3'd3:    tx_byte = buf_q[31:24];
      3'd4:    tx_byte = buf_q[23:16];
      3'd5:    tx_byte = buf_q[15:8];
      3'd6:    tx_byte = buf_q[7:0];
      default: tx_byte = TRAILER;
    endcase
  end

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      src_q      <= 1'b0;
      last_src_q <= 1'b1;
      idx_q      <= 3'd0;
      timer_q    <= '0;
      data_q     <= 8'd0;
      en_q       <= 1'b0;
      grant0_q   <= 1'b0;
      grant1_q   <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      grant0_q <= 1'b0;
      grant1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req0 | bus.req1) begin
            buf_q    <= pick1 ? bus.msg1 : bus.msg0;
            src_q    <= pick1;
            grant0_q <= ~pick1;
            grant1_q <= pick1;
            busy_q   <= 1'b1;
            idx_q    <= 3'd0;
            state_q  <= SEND;
          end
        end
        SEND: begin
          // No timeout here: a transmitter that is not ready is simply waited on.
          if (bus.uart_ready) begin
            data_q  <= tx_byte;
            en_q    <= 1'b1;
            timer_q <= '0;
            state_q <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          // Acknowledge is checked first so ready falling on the last timer
          // count is still a good handshake.
          if (!bus.uart_ready) begin
            en_q <= 1'b0;
            if (idx_q == 3'd7) begin
              last_src_q <= src_q;
              busy_q     <= 1'b0;
              state_q    <= IDLE;
            end else begin
              idx_q   <= idx_q + 3'd1;
              state_q <= SEND;
            end
          end else if (timer_q == TMAX) begin
            // Abort: remaining bytes are dropped, requester is not re-granted.
            en_q       <= 1'b0;
            err_q      <= 1'b1;
            busy_q     <= 1'b0;
            last_src_q <= src_q;
            state_q    <= IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant0            = grant0_q;
  assign bus.grant1            = grant1_q;
  assign bus.uart_data         = data_q;
  assign bus.uart_clock_enable = en_q;
  assign bus.busy              = busy_q;
  assign bus.timeout_err       = err_q;
  assign state_o               = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Drives both requesters and models a UART transmitter whose ready-low time
//   and stuck behaviour are programmable. Expected bytes and grant channels
//   are queued when a request is issued and compared when the DUT emits them.
//   DUT acts on the falling edge; the bench samples and drives around the
//   rising edge.
module tb_uart_tx_arbiter;

  localparam int TO = 8;

  logic       clock;
  logic       rst_n;
  logic [1:0] state_o;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(
    .HEADER_BASE (8'hA0),
    .TRAILER     (8'h0A),
    .TIMEOUT     (TO)
  ) dut (
    .clock   (clock),
    .reset   (rst_n),
    .bus     (bus),
    .state_o (state_o)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  logic       exp_g_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- UART model + monitor ----------------
  int  lat = 1;          // clocks ready stays low after accepting a byte
  bit  stuck_mode = 0;   // keep ready high after the 3rd byte of a packet
  bit  stuck_active = 0;
  int  low_cnt = 0;
  int  en_w = 0;
  int  pkt_bytes = 0;
  int  g0_cnt = 0;
  int  g1_cnt = 0;
  bit  prev_en = 0;
  bit  prev_g = 0;

  always @(posedge clock) begin
    if (!rst_n) begin
      bus.uart_ready = 1'b1;
      prev_en      = 0;
      prev_g       = 0;
      low_cnt      = 0;
      stuck_active = 0;
    end else begin
      if (bus.grant0 || bus.grant1) begin
        chk("grant_exp_avail", 64'(exp_g_q.size() != 0), 1);
        chk("grant_onehot", 64'(bus.grant0 & bus.grant1), 0);
        chk("grant_pulse", 64'(prev_g), 0);
        if (exp_g_q.size() != 0) chk("grant_ch", 64'(bus.grant1), 64'(exp_g_q.pop_front()));
        if (bus.grant0) g0_cnt++;
        else g1_cnt++;
        pkt_bytes = 0;
      end
      prev_g = bus.grant0 | bus.grant1;

      if (!bus.uart_ready && low_cnt > 0) begin
        low_cnt--;
        if (low_cnt == 0) bus.uart_ready = 1'b1;
      end

      if (bus.uart_clock_enable && !prev_en) begin
        en_w = 1;
        chk("byte_exp_avail", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("byte", 64'(bus.uart_data), 64'(exp_q.pop_front()));
        if (stuck_mode && pkt_bytes == 2) begin
          stuck_active = 1;
        end else begin
          bus.uart_ready = 1'b0;
          low_cnt = lat;
        end
        pkt_bytes++;
      end else if (bus.uart_clock_enable) begin
        en_w++;
      end else if (prev_en) begin
        chk("en_width", 64'(en_w), stuck_active ? 64'(TO) : 64'd1);
        stuck_active = 0;
      end
      prev_en = bus.uart_clock_enable;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic push_pkt(input logic ch, input logic [47:0] m, input int nb);
    logic [7:0] b[8];
    b[0] = 8'hA0 | {7'd0, ch};
    for (int i = 1; i <= 6; i++) b[i] = m[47 - 8 * (i - 1) -: 8];
    b[7] = 8'h0A;
    for (int i = 0; i < nb; i++) exp_q.push_back(b[i]);
    exp_g_q.push_back(ch);
  endtask

  task automatic wait_grant(input logic ch);
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      if (ch ? bus.grant1 : bus.grant0) ok = 1;
    end
    chk("wait_grant", 64'(ok), 1);
  endtask

  task automatic wait_any_grant(output int at);
    bit ok = 0;
    at = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      if (bus.grant0 || bus.grant1) begin
        ok = 1;
        at = cyc;
      end
    end
    chk("wait_any_grant", 64'(ok), 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      tick();
      if (!bus.busy) ok = 1;
    end
    chk("wait_idle", 64'(ok), 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data"},  64'(bus.uart_data), 0);
    chk({tag, "_en"},    64'(bus.uart_clock_enable), 0);
    chk({tag, "_g0"},    64'(bus.grant0), 0);
    chk({tag, "_g1"},    64'(bus.grant1), 0);
    chk({tag, "_busy"},  64'(bus.busy), 0);
    chk({tag, "_err"},   64'(bus.timeout_err), 0);
    chk({tag, "_state"}, 64'(state_o), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t_prev;
    int t_now;
    int g0_before;
    bit ok;

    rst_n    = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.msg0 = '0;
    bus.msg1 = '0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Single request, ideal UART.
    lat = 1;
    push_pkt(1'b0, 48'h0123456789AB, 8);
    bus.msg0 = 48'h0123456789AB;
    bus.req0 = 1'b1;
    wait_grant(1'b0);
    bus.req0 = 1'b0;
    wait_idle();
    tick();
    chk("t1_empty", 64'(exp_q.size()), 0);
    chk("t1_err", 64'(bus.timeout_err), 0);
    chk("t1_state", 64'(state_o), 0);

    // Both held: ch0, ch1, ch0 with 17-clock grant spacing.
    do_reset();
    bus.msg0 = 48'h0123456789AB;
    bus.msg1 = 48'hFFEEDDCCBBAA;
    push_pkt(1'b0, bus.msg0, 8);
    push_pkt(1'b1, bus.msg1, 8);
    push_pkt(1'b0, bus.msg0, 8);
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 3; i++) begin
      wait_any_grant(t_now);
      if (i > 0) chk("rr_gap", 64'(t_now - t_prev), 17);
      t_prev = t_now;
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    wait_idle();
    tick();
    chk("t2_empty", 64'(exp_q.size()), 0);
    chk("t2_grants_left", 64'(exp_g_q.size()), 0);

    // Slow UART: ready low 5 clocks per byte.
    lat = 5;
    push_pkt(1'b0, 48'hDEADBEEFCAFE, 8);
    bus.msg0 = 48'hDEADBEEFCAFE;
    bus.req0 = 1'b1;
    wait_grant(1'b0);
    bus.req0 = 1'b0;
    wait_idle();
    tick();
    chk("t3_empty", 64'(exp_q.size()), 0);
    lat = 1;

    // Timeout on the 3rd byte, then a normal ch1 packet.
    stuck_mode = 1;
    push_pkt(1'b0, 48'h102030405060, 3);
    bus.msg0 = 48'h102030405060;
    bus.req0 = 1'b1;
    wait_grant(1'b0);
    bus.req0 = 1'b0;
    wait_idle();
    stuck_mode = 0;
    repeat (2) tick();
    chk("t4_err_set", 64'(bus.timeout_err), 1);
    chk("t4_empty", 64'(exp_q.size()), 0);
    chk("t4_state", 64'(state_o), 0);
    push_pkt(1'b1, 48'h5A5AA5A51234, 8);
    bus.msg1 = 48'h5A5AA5A51234;
    bus.req1 = 1'b1;
    wait_grant(1'b1);
    bus.req1 = 1'b0;
    wait_idle();
    tick();
    chk("t4_after_empty", 64'(exp_q.size()), 0);
    chk("t4_err_sticky", 64'(bus.timeout_err), 1);

    // Reset during byte 4, then ch1 restarts from the header.
    push_pkt(1'b0, 48'hA1B2C3D4E5F6, 4);
    bus.msg0 = 48'hA1B2C3D4E5F6;
    bus.req0 = 1'b1;
    wait_grant(1'b0);
    bus.req0 = 1'b0;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      if (exp_q.size() == 0) ok = 1;
    end
    chk("t5_reach_byte4", 64'(ok), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t5_async");
    exp_q.delete();
    exp_g_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    push_pkt(1'b1, 48'h00FF00FF00FF, 8);
    bus.msg1 = 48'h00FF00FF00FF;
    bus.req1 = 1'b1;
    wait_grant(1'b1);
    bus.req1 = 1'b0;
    wait_idle();
    tick();
    chk("t5_empty", 64'(exp_q.size()), 0);

    // req0 withdrawn while ch1 is being served: never granted.
    g0_before = g0_cnt;
    push_pkt(1'b1, 48'hCAFEF00DBEEF, 8);
    bus.msg1 = 48'hCAFEF00DBEEF;
    bus.req1 = 1'b1;
    wait_grant(1'b1);
    bus.req1 = 1'b0;
    repeat (3) tick();
    bus.msg0 = 48'h777777777777;
    bus.req0 = 1'b1;
    repeat (4) tick();
    bus.req0 = 1'b0;
    wait_idle();
    repeat (4) tick();
    chk("t6_no_grant0", 64'(g0_cnt), 64'(g0_before));
    chk("t6_busy", 64'(bus.busy), 0);
    chk("t6_state", 64'(state_o), 0);
    chk("t6_empty", 64'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
